// File: rtl/pkt_pkg.sv
// rtl/pkt_pkg.sv - shared frame constants and types for the rx_frame_assembler / pkt_handler pair
package pkt_pkg;

    localparam int FRAME_BYTES = 8;

    typedef logic [7:0] pkt_byte_t;

    localparam pkt_byte_t SYNC_BYTE = 8'h96;
    localparam pkt_byte_t KILL_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        HUNT,
        COLLECT,
        HOLD,
        EMIT
    } asm_state_t;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    function automatic logic is_frame_start(input pkt_byte_t b);
        return (b == SYNC_BYTE) || (b == KILL_BYTE);
    endfunction

endpackage

// File: rtl/rx_frame_assembler_if.sv
// rtl/rx_frame_assembler_if.sv - frame burst handshake between rx_frame_assembler and pkt_handler
interface rx_frame_assembler_if;
    import pkt_pkg::*;

    pkt_byte_t rx_frame;
    logic      rx_valid;
    logic      rx_ready;

    modport master (
        output rx_frame,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_frame,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver: line synchroniser, start-bit qualification, centre sampling, stop check
module uart_rx
    import pkt_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rxd,
    output pkt_byte_t rx_byte,
    output logic      byte_valid,
    output logic      ferr,
    output logic      line_idle
);

    localparam int BIT_CYC  = CLK_HZ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

    logic             rxd_s1_q, rxd_s2_q, rxd_s3_q;
    uart_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    pkt_byte_t        shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             ferr_q, ferr_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        ferr_d       = 1'b0;
        case (state_q)
            U_IDLE: begin
                cnt_d = '0;
                // Arm only on a true falling edge so a stuck-low line after a bad stop bit is not re-read.
                if (rxd_s3_q && !rxd_s2_q) state_d = U_START;
            end
            U_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rxd_s2_q ? U_IDLE : U_DATA;
                end
            end
            U_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxd_s2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = U_STOP;
                end
            end
            U_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d        = '0;
                    byte_valid_d = rxd_s2_q;
                    ferr_d       = !rxd_s2_q;
                    state_d      = U_IDLE;
                end
            end
            default: state_d = U_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_s1_q     <= 1'b1;
            rxd_s2_q     <= 1'b1;
            rxd_s3_q     <= 1'b1;
            state_q      <= U_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            rxd_s1_q     <= rxd;
            rxd_s2_q     <= rxd_s1_q;
            rxd_s3_q     <= rxd_s2_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            ferr_q       <= ferr_d;
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = byte_valid_q;
    assign ferr       = ferr_q;
    assign line_idle  = (state_q == U_IDLE);

endmodule

// File: rtl/rx_frame_assembler.sv
// rtl/rx_frame_assembler.sv - hunts UART bytes for frame starts, buffers 8 bytes, replays them as one burst
// Optional RX_STATS_EN adds saturating frames_ok / frames_dropped counters.
module rx_frame_assembler
    import pkt_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BAUD        = 115_200,
    parameter int TIMEOUT_CYC = 20_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rxd,
    rx_frame_assembler_if.master bus,
    output logic                 frame_drop,
    output logic                 overrun
`ifdef RX_STATS_EN
    ,
    output logic [15:0]          frames_ok,
    output logic [15:0]          frames_dropped
`endif
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]        LAST_IDX  = 4'(FRAME_BYTES - 1);
    localparam logic [3:0]        DONE_IDX  = 4'(FRAME_BYTES);

    pkt_byte_t rx_byte;
    logic      byte_valid;
    logic      ferr;
    logic      line_idle;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_uart_rx (
        .clk        (clk),
        .rst        (rst),
        .rxd        (uart_rxd),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .ferr       (ferr),
        .line_idle  (line_idle)
    );

    asm_state_t        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    pkt_byte_t         frame_buf_q [FRAME_BYTES];
    pkt_byte_t         frame_buf_d [FRAME_BYTES];
    pkt_byte_t         rx_frame_q, rx_frame_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_drop_q, frame_drop_d;
    logic              overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        idle_cnt_d   = idle_cnt_q;
        frame_buf_d  = frame_buf_q;
        rx_frame_d   = rx_frame_q;
        rx_valid_d   = 1'b0;
        frame_drop_d = 1'b0;
        overrun_d    = 1'b0;
        case (state_q)
            HUNT: begin
                idle_cnt_d = '0;
                if (byte_valid && is_frame_start(rx_byte)) begin
                    frame_buf_d[0] = rx_byte;
                    idx_d          = 4'd1;
                    state_d        = COLLECT;
                end
            end
            COLLECT: begin
                // A byte landing on the timeout cycle still counts: it is tested first.
                if (byte_valid) begin
                    frame_buf_d[idx_q[2:0]] = rx_byte;
                    idle_cnt_d              = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = HOLD;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else if (ferr || (line_idle && idle_cnt_q == IDLE_LAST)) begin
                    frame_drop_d = 1'b1;
                    idx_d        = '0;
                    state_d      = HUNT;
                end else if (line_idle) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                overrun_d = byte_valid;
                if (bus.rx_ready) begin
                    rx_valid_d = 1'b1;
                    rx_frame_d = frame_buf_q[0];
                    idx_d      = 4'd1;
                    state_d    = EMIT;
                end
            end
            EMIT: begin
                overrun_d = byte_valid;
                if (idx_q == DONE_IDX) begin
                    idx_d   = '0;
                    state_d = HUNT;
                end else begin
                    rx_valid_d = 1'b1;
                    rx_frame_d = frame_buf_q[idx_q[2:0]];
                    idx_d      = idx_q + 4'd1;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= HUNT;
            idx_q        <= '0;
            idle_cnt_q   <= '0;
            frame_buf_q  <= '{default: '0};
            rx_frame_q   <= '0;
            rx_valid_q   <= 1'b0;
            frame_drop_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            idle_cnt_q   <= idle_cnt_d;
            frame_buf_q  <= frame_buf_d;
            rx_frame_q   <= rx_frame_d;
            rx_valid_q   <= rx_valid_d;
            frame_drop_q <= frame_drop_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.rx_frame = rx_frame_q;
    assign bus.rx_valid = rx_valid_q;
    assign frame_drop   = frame_drop_q;
    assign overrun      = overrun_q;

`ifdef RX_STATS_EN
    logic [15:0] frames_ok_q, frames_ok_d;
    logic [15:0] frames_dropped_q, frames_dropped_d;

    always_comb begin
        frames_ok_d      = frames_ok_q;
        frames_dropped_d = frames_dropped_q;
        if (state_q == EMIT && idx_q == DONE_IDX && frames_ok_q != 16'hFFFF)
            frames_ok_d = frames_ok_q + 16'd1;
        if (frame_drop_d && frames_dropped_q != 16'hFFFF)
            frames_dropped_d = frames_dropped_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frames_ok_q      <= '0;
            frames_dropped_q <= '0;
        end else begin
            frames_ok_q      <= frames_ok_d;
            frames_dropped_q <= frames_dropped_d;
        end
    end

    assign frames_ok      = frames_ok_q;
    assign frames_dropped = frames_dropped_q;
`endif

endmodule

// File: tb/tb_rx_frame_assembler.sv
// tb/tb_rx_frame_assembler.sv - randomized self-checking bench for rx_frame_assembler
module tb_rx_frame_assembler;
    import pkt_pkg::*;

    localparam int CLK_HZ      = 1_600_000;
    localparam int BAUD        = 100_000;
    localparam int TIMEOUT_CYC = 400;
    localparam int BIT_CYC     = CLK_HZ / BAUD;

    typedef struct {
        logic [7:0] b;
        bit         ferr;
        bit         gap;
    } tok_t;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic uart_rxd = 1'b1;
    logic frame_drop;
    logic overrun;
`ifdef RX_STATS_EN
    logic [15:0] frames_ok;
    logic [15:0] frames_dropped;
`endif

    rx_frame_assembler_if bus ();

    rx_frame_assembler #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rxd   (uart_rxd),
        .bus        (bus),
        .frame_drop (frame_drop),
        .overrun    (overrun)
`ifdef RX_STATS_EN
        ,
        .frames_ok      (frames_ok),
        .frames_dropped (frames_dropped)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          drops_seen = 0;
    int          overruns_seen = 0;
    logic [63:0] got_frames [$];
    logic [63:0] exp_frames [$];
    logic [7:0]  beats [$];
    logic [63:0] mon_f;
    int          exp_drops;
    int          exp_ok_total = 0;
    int          exp_drop_total = 0;
    tok_t        toks [$];

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor: collect each rx_valid run as one packed frame.
    always @(negedge clk) begin
        if (!rst) begin
            beats.delete();
        end else begin
            if (frame_drop) drops_seen++;
            if (overrun) overruns_seen++;
            if (bus.rx_valid) begin
                beats.push_back(bus.rx_frame);
            end else if (beats.size() != 0) begin
                chk_eq("burst_len", 64'(beats.size()), 64'(8));
                mon_f = '0;
                foreach (beats[i]) mon_f = {mon_f[55:0], beats[i]};
                got_frames.push_back(mon_f);
                beats.delete();
            end
        end
    end

    function automatic void add_byte(input logic [7:0] b, input bit ferr = 1'b0);
        toks.push_back('{b: b, ferr: ferr, gap: 1'b0});
    endfunction

    function automatic void add_gap();
        toks.push_back('{b: 8'h00, ferr: 1'b0, gap: 1'b1});
    endfunction

    function automatic logic [7:0] junk();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'h96 || b == 8'hFF);
        return b;
    endfunction

    function automatic void add_frame();
        add_byte($urandom_range(0, 1) ? 8'h96 : 8'hFF);
        repeat (7) add_byte(8'($urandom));
    endfunction

    // Reference: a frame is a start byte plus seven more good bytes with no gap or framing error between.
    function automatic void model();
        logic [7:0]  cur [$];
        bit          coll = 1'b0;
        logic [63:0] f;
        exp_frames.delete();
        exp_drops = 0;
        foreach (toks[i]) begin
            if (toks[i].gap || toks[i].ferr) begin
                if (coll) exp_drops++;
                coll = 1'b0;
            end else if (!coll) begin
                if (toks[i].b == 8'h96 || toks[i].b == 8'hFF) begin
                    cur.delete();
                    cur.push_back(toks[i].b);
                    coll = 1'b1;
                end
            end else begin
                cur.push_back(toks[i].b);
                if (cur.size() == 8) begin
                    f = '0;
                    foreach (cur[j]) f = {f[55:0], cur[j]};
                    exp_frames.push_back(f);
                    coll = 1'b0;
                end
            end
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        uart_rxd = !bad_stop;
        repeat (BIT_CYC) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
    endtask

    task automatic send_tokens();
        foreach (toks[i]) begin
            if (toks[i].gap) begin
                uart_rxd = 1'b1;
                repeat (TIMEOUT_CYC + 100) @(negedge clk);
            end else begin
                send_byte(toks[i].b, toks[i].ferr);
            end
        end
    endtask

    task automatic run_tokens(input string tag);
        int fb;
        int db;
        int ob;
        fb = got_frames.size();
        db = drops_seen;
        ob = overruns_seen;
        model();
        send_tokens();
        repeat (4 * BIT_CYC) @(negedge clk);
        chk_eq({tag, "_nframes"}, 64'(got_frames.size() - fb), 64'(exp_frames.size()));
        foreach (exp_frames[i])
            if (fb + i < got_frames.size()) chk_eq({tag, "_frame"}, got_frames[fb + i], exp_frames[i]);
        chk_eq({tag, "_drops"}, 64'(drops_seen - db), 64'(exp_drops));
        chk_eq({tag, "_overrun"}, 64'(overruns_seen - ob), 64'(0));
        exp_ok_total   += exp_frames.size();
        exp_drop_total += exp_drops;
`ifdef RX_STATS_EN
        chk_eq({tag, "_stat_ok"}, 64'(frames_ok), 64'(exp_ok_total));
        chk_eq({tag, "_stat_drop"}, 64'(frames_dropped), 64'(exp_drop_total));
`endif
    endtask

    logic [7:0]  hb [8];
    logic [63:0] hb_pack;
    int          fb0;
    int          ob0;
    int          kind;

    initial begin
        bus.rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk_eq("rst_rx_valid", 64'(bus.rx_valid), 64'(0));
        chk_eq("rst_rx_frame", 64'(bus.rx_frame), 64'(0));
        chk_eq("rst_frame_drop", 64'(frame_drop), 64'(0));
        chk_eq("rst_overrun", 64'(overrun), 64'(0));
        rst = 1'b1;
        repeat (5) @(negedge clk);

        toks.delete();
        add_byte(8'h96); add_byte(8'h0F); add_byte(8'h01); add_byte(8'h00);
        add_byte(8'hB3); add_byte(8'hC5); add_byte(8'h33); add_byte(8'h62);
        run_tokens("basic");

        toks.delete();
        add_byte(8'h12); add_byte(8'h34);
        repeat (8) add_byte(8'hFF);
        run_tokens("kill");

        toks.delete();
        add_byte(8'h96); add_byte(8'h0F); add_byte(8'h01);
        add_gap();
        add_frame();
        run_tokens("timeout");

        toks.delete();
        add_byte(8'h96); add_byte(8'h0F); add_byte(8'h01); add_byte(8'h00, 1'b1);
        add_frame();
        run_tokens("ferr");

        for (int s = 0; s < 8; s++) begin
            toks.delete();
            kind = $urandom_range(0, 2);
            case (kind)
                0: begin
                    repeat ($urandom_range(0, 3)) add_byte(junk());
                    add_byte(junk(), 1'b1);
                    add_frame();
                end
                1: begin
                    add_byte(8'h96);
                    repeat ($urandom_range(0, 6)) add_byte(8'($urandom));
                    add_gap();
                    add_frame();
                end
                default: begin
                    add_byte(8'hFF);
                    repeat ($urandom_range(0, 5)) add_byte(8'($urandom));
                    add_byte(8'($urandom), 1'b1);
                    add_frame();
                end
            endcase
            run_tokens("rand");
        end

        // Held frame with back-pressure, then an overrun byte while waiting.
        hb[0] = 8'h96;
        for (int k = 1; k < 8; k++) hb[k] = 8'($urandom);
        hb_pack = '0;
        for (int k = 0; k < 8; k++) hb_pack = {hb_pack[55:0], hb[k]};
        fb0 = got_frames.size();
        ob0 = overruns_seen;
        bus.rx_ready = 1'b0;
        for (int k = 0; k < 8; k++) send_byte(hb[k], 1'b0);
        repeat (10 * BIT_CYC) @(negedge clk);
        chk_eq("hold_no_burst", 64'(got_frames.size() - fb0), 64'(0));
        send_byte(8'h5A, 1'b0);
        repeat (2 * BIT_CYC) @(negedge clk);
        chk_eq("hold_overrun", 64'(overruns_seen - ob0), 64'(1));
        chk_eq("hold_idle_valid", 64'(bus.rx_valid), 64'(0));
        @(negedge clk);
        bus.rx_ready = 1'b1;
        #1;
        chk_eq("hold_valid_not_comb", 64'(bus.rx_valid), 64'(0));
        @(negedge clk);
        chk_eq("hold_first_valid", 64'(bus.rx_valid), 64'(1));
        chk_eq("hold_first_beat", 64'(bus.rx_frame), 64'(hb[0]));
        bus.rx_ready = 1'b0;
        repeat (20) @(negedge clk);
        chk_eq("hold_nframes", 64'(got_frames.size() - fb0), 64'(1));
        if (got_frames.size() > fb0) chk_eq("hold_frame", got_frames[fb0], hb_pack);
        bus.rx_ready = 1'b1;
        exp_ok_total++;

        // Reset in the middle of a burst.
        toks.delete();
        add_frame();
        for (int k = 0; k < 7; k++) send_byte(toks[k].b, 1'b0);
        fork
            send_byte(toks[7].b, 1'b0);
            begin
                for (int w = 0; w < 40 * BIT_CYC && bus.rx_valid !== 1'b1; w++) @(negedge clk);
                chk_eq("rst_emit_seen", 64'(bus.rx_valid), 64'(1));
                repeat (3) @(negedge clk);
                chk_eq("rst_beat3", 64'(bus.rx_frame), 64'(toks[3].b));
                #1 rst = 1'b0;
                #1;
                chk_eq("rst_async_valid", 64'(bus.rx_valid), 64'(0));
                chk_eq("rst_async_frame", 64'(bus.rx_frame), 64'(0));
            end
        join
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_ok_total   = 0;
        exp_drop_total = 0;
`ifdef RX_STATS_EN
        chk_eq("rst_stat_ok", 64'(frames_ok), 64'(0));
        chk_eq("rst_stat_drop", 64'(frames_dropped), 64'(0));
`endif
        repeat (5) @(negedge clk);
        toks.delete();
        add_frame();
        run_tokens("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation still running, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
